// File: rtl/ps2_key_decoder_pkg.sv
// Shared constants for the PS/2 keyboard front end of car_ctl: prefix codes,
// mapped scancodes, key vector indices and the receiver state type.
package er_ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    localparam logic [7:0] SC_RIGHT_EXT = 8'h74;
    localparam logic [7:0] SC_LEFT_EXT  = 8'h6B;
    localparam logic [7:0] SC_DOWN_EXT  = 8'h72;
    localparam logic [7:0] SC_UP_EXT    = 8'h75;
    localparam logic [7:0] SC_D         = 8'h23;
    localparam logic [7:0] SC_A         = 8'h1C;
    localparam logic [7:0] SC_S         = 8'h1B;
    localparam logic [7:0] SC_W         = 8'h1D;

    localparam logic [1:0] KEY_RIGHT = 2'd3;
    localparam logic [1:0] KEY_LEFT  = 2'd2;
    localparam logic [1:0] KEY_DOWN  = 2'd1;
    localparam logic [1:0] KEY_UP    = 2'd0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } key_map_t;

    // Keypad arrows (NumLock off) arrive without the E0 prefix and stay unmapped.
    function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.idx = KEY_UP;
        if (ext) begin
            case (code)
                SC_RIGHT_EXT: m.idx = KEY_RIGHT;
                SC_LEFT_EXT:  m.idx = KEY_LEFT;
                SC_DOWN_EXT:  m.idx = KEY_DOWN;
                SC_UP_EXT:    m.idx = KEY_UP;
                default:      m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_D:    m.idx = KEY_RIGHT;
                SC_A:    m.idx = KEY_LEFT;
                SC_S:    m.idx = KEY_DOWN;
                SC_W:    m.idx = KEY_UP;
                default: m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_rx.sv
// PS/2 frame receiver: input synchronizers, ps2_clk glitch filter, framing FSM
// and inter-edge timeout. Emits one good byte or one error pulse per frame.
import er_ps2_pkg::*;

module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 13000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_ok,
    output logic       err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          filt_level, fall;
    logic [FW-1:0] filt_cnt;

    rx_state_t     state, state_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic [TW-1:0] tcnt;
    logic          timeout_hit, ok_next, err_next;

    // The filtered level only follows the line after FILTER_LEN agreeing samples.
    always_ff @(posedge pclk) begin
        if (rst) begin
            clk_s1     <= 1'b1;
            clk_s2     <= 1'b1;
            data_s1    <= 1'b1;
            data_s2    <= 1'b1;
            filt_level <= 1'b1;
            filt_cnt   <= '0;
            fall       <= 1'b0;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
            fall    <= 1'b0;
            if (clk_s2 == filt_level) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_level <= clk_s2;
                filt_cnt   <= '0;
                fall       <= filt_level;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign timeout_hit = (state != RX_IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next = state;
        ok_next    = 1'b0;
        err_next   = 1'b0;
        case (state)
            RX_IDLE: begin
                if (fall) begin
                    if (!data_s2) state_next = RX_DATA;
                    else          err_next   = 1'b1;
                end
            end
            RX_DATA: begin
                if (fall && bit_cnt == 3'd7) state_next = RX_PARITY;
            end
            RX_PARITY: begin
                if (fall) state_next = RX_STOP;
            end
            RX_STOP: begin
                if (fall) begin
                    state_next = RX_IDLE;
                    if (data_s2 && (^{shift, parity_bit})) ok_next  = 1'b1;
                    else                                   err_next = 1'b1;
                end
            end
            default: state_next = RX_IDLE;
        endcase
        if (timeout_hit) begin
            state_next = RX_IDLE;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            tcnt       <= '0;
            byte_ok    <= 1'b0;
            err        <= 1'b0;
        end else begin
            state   <= state_next;
            byte_ok <= ok_next;
            err     <= err_next;
            if (fall || state == RX_IDLE) tcnt <= '0;
            else                          tcnt <= tcnt + TW'(1);
            if (fall) begin
                case (state)
                    RX_IDLE:   bit_cnt <= '0;
                    RX_DATA: begin
                        shift   <= {data_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    RX_PARITY: parity_bit <= data_s2;
                    default:   ;
                endcase
            end
        end
    end

    assign data_byte = shift;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder feeding car_ctl: tracks E0/F0 prefixes and turns
// make/break codes for WASD and the arrow keys into a held-key vector.
import er_ps2_pkg::*;

module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 13000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       frame_err
);

    logic [7:0] data_byte;
    logic       byte_ok, rx_err;
    logic       ext, brk;
    key_map_t   lookup;

    ps2_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .pclk     (pclk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_byte(data_byte),
        .byte_ok  (byte_ok),
        .err      (rx_err)
    );

    assign lookup    = map_key(ext, data_byte);
    assign frame_err = rx_err;

    // A framing error drops any pending prefix so the next byte is a fresh make code.
    always_ff @(posedge pclk) begin
        if (rst) begin
            key            <= '0;
            scancode       <= '0;
            scancode_valid <= 1'b0;
            ext            <= 1'b0;
            brk            <= 1'b0;
        end else begin
            scancode_valid <= 1'b0;
            if (byte_ok) begin
                scancode       <= data_byte;
                scancode_valid <= 1'b1;
                if (data_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else if (data_byte == SC_BREAK) begin
                    brk <= 1'b1;
                end else begin
                    if (lookup.hit) key[lookup.idx] <= ~brk;
                    ext <= 1'b0;
                    brk <= 1'b0;
                end
            end else if (rx_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: a PS/2 bus model drives frames, a
// reference model queues expected {scancode, key}, a monitor records DUT output.
module tb_ps2_key_decoder;

    localparam int HALF = 50;

    typedef struct {
        logic [7:0] sc;
        logic [3:0] key;
        int         cyc;
    } obs_t;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] key;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       frame_err;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   err_count = 0;
    int   last_fall = 0;
    int   obs_rd = 0;
    int   err_rd = 0;
    obs_t obs_q[$];
    int   err_cyc[$];
    obs_t exp_q[$];

    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [3:0] m_key = 4'b0000;

    ps2_key_decoder dut (
        .pclk          (pclk),
        .rst           (rst),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .key           (key),
        .scancode      (scancode),
        .scancode_valid(scancode_valid),
        .frame_err     (frame_err)
    );

    always #8 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    // Monitor: record every scancode_valid cycle and every frame_err cycle.
    always @(negedge pclk) begin
        if (scancode_valid) obs_q.push_back('{scancode, key, cyc});
        if (frame_err) begin
            err_count = err_count + 1;
            err_cyc.push_back(cyc);
        end
    end

    // Reference decoder, written from the key map table rather than the RTL.
    task automatic model_byte(input logic [7:0] b);
        obs_t e;
        int   idx;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            idx = -1;
            if (m_ext) begin
                if (b == 8'h74) idx = 3;
                if (b == 8'h6B) idx = 2;
                if (b == 8'h72) idx = 1;
                if (b == 8'h75) idx = 0;
            end else begin
                if (b == 8'h23) idx = 3;
                if (b == 8'h1C) idx = 2;
                if (b == 8'h1B) idx = 1;
                if (b == 8'h1D) idx = 0;
            end
            if (idx >= 0) m_key[idx] = ~m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        e.sc  = b;
        e.key = m_key;
        e.cyc = 0;
        exp_q.push_back(e);
    endtask

    // Bus model: start, 8 data bits LSB first, odd parity, stop; nbits truncates the frame.
    task automatic send_bits(input logic [7:0] b, input bit flip, input bit glitch, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            if (glitch) begin
                repeat (20) @(negedge pclk);
                ps2_clk = 1'b0;
                repeat (3) @(negedge pclk);
                ps2_clk = 1'b1;
                repeat (HALF - 23) @(negedge pclk);
            end else begin
                repeat (HALF) @(negedge pclk);
            end
            ps2_clk   = 1'b0;
            last_fall = cyc;
            repeat (HALF) @(negedge pclk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge pclk);
    endtask

    task automatic send_good(input logic [7:0] b, input bit glitch);
        model_byte(b);
        send_bits(b, 1'b0, glitch, 11);
    endtask

    task automatic send_bad_parity(input logic [7:0] b);
        m_ext = 1'b0;
        m_brk = 1'b0;
        send_bits(b, 1'b1, 1'b0, 11);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (4) @(negedge pclk);
        compared++; if (key !== 4'b0) begin mismatched++; $display("[TB] FAIL reset_key: got %b want 0000", key); end
        compared++; if (scancode !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_scancode: got %h want 00", scancode); end
        compared++; if (scancode_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b want 0", scancode_valid); end
        compared++; if (frame_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b want 0", frame_err); end
        rst = 1'b0;
        repeat (5) @(negedge pclk);
    endtask

    task automatic test_make;
        int e0;
        obs_t e, o;
        e0 = err_count;
        send_good(8'h1D, 1'b0);
        compared++;
        if (obs_rd < obs_q.size()) begin
            if (obs_q[obs_rd].cyc - last_fall !== 12) begin
                mismatched++;
                $display("[TB] FAIL make_latency: got %0d cycles from stop edge want 12", obs_q[obs_rd].cyc - last_fall);
            end
        end else begin
            mismatched++; $display("[TB] FAIL make_latency: got no scancode_valid want one");
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_rd >= obs_q.size()) begin
                mismatched++; $display("[TB] FAIL make_missing: got nothing want sc=%h key=%b", e.sc, e.key);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.sc !== e.sc || o.key !== e.key) begin
                    mismatched++; $display("[TB] FAIL make_data: got sc=%h key=%b want sc=%h key=%b", o.sc, o.key, e.sc, e.key);
                end
            end
        end
        compared++; if (obs_q.size() != obs_rd) begin mismatched++; $display("[TB] FAIL make_extra: got %0d extra valid pulses want 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
        compared++; if (err_count - e0 != 0) begin mismatched++; $display("[TB] FAIL make_err: got %0d errors want 0", err_count - e0); end
    endtask

    task automatic test_ext;
        logic [7:0] seq[7] = '{8'hF0, 8'h1D, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        obs_t e, o;
        foreach (seq[i]) send_good(seq[i], 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_rd >= obs_q.size()) begin
                mismatched++; $display("[TB] FAIL ext_missing: got nothing want sc=%h key=%b", e.sc, e.key);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.sc !== e.sc || o.key !== e.key) begin
                    mismatched++; $display("[TB] FAIL ext_data: got sc=%h key=%b want sc=%h key=%b", o.sc, o.key, e.sc, e.key);
                end
            end
        end
        compared++; if (obs_q.size() != obs_rd) begin mismatched++; $display("[TB] FAIL ext_extra: got %0d extra valid pulses want 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
        compared++; if (key !== 4'b0000) begin mismatched++; $display("[TB] FAIL ext_final: got %b want 0000", key); end
    endtask

    task automatic test_multi;
        logic [7:0] seq[6] = '{8'h1D, 8'h23, 8'hF0, 8'h1D, 8'hF0, 8'h23};
        obs_t e, o;
        foreach (seq[i]) send_good(seq[i], 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_rd >= obs_q.size()) begin
                mismatched++; $display("[TB] FAIL multi_missing: got nothing want sc=%h key=%b", e.sc, e.key);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.sc !== e.sc || o.key !== e.key) begin
                    mismatched++; $display("[TB] FAIL multi_data: got sc=%h key=%b want sc=%h key=%b", o.sc, o.key, e.sc, e.key);
                end
            end
        end
        compared++; if (obs_q.size() != obs_rd) begin mismatched++; $display("[TB] FAIL multi_extra: got %0d extra valid pulses want 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
    endtask

    task automatic test_parity_err;
        int e0;
        obs_t e, o;
        e0 = err_count;
        send_bad_parity(8'h1C);
        compared++; if (err_count - e0 != 1) begin mismatched++; $display("[TB] FAIL parity_err: got %0d errors want 1", err_count - e0); end
        send_good(8'hE0, 1'b0);
        send_bad_parity(8'h74);
        send_good(8'h74, 1'b0);
        compared++; if (err_count - e0 != 2) begin mismatched++; $display("[TB] FAIL parity_err2: got %0d errors want 2", err_count - e0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_rd >= obs_q.size()) begin
                mismatched++; $display("[TB] FAIL parity_missing: got nothing want sc=%h key=%b", e.sc, e.key);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.sc !== e.sc || o.key !== e.key) begin
                    mismatched++; $display("[TB] FAIL parity_data: got sc=%h key=%b want sc=%h key=%b", o.sc, o.key, e.sc, e.key);
                end
            end
        end
        compared++; if (obs_q.size() != obs_rd) begin mismatched++; $display("[TB] FAIL parity_extra: got %0d extra valid pulses want 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
        compared++; if (key !== 4'b0000) begin mismatched++; $display("[TB] FAIL parity_key: got %b want 0000", key); end
    endtask

    task automatic test_timeout;
        int e0, lat;
        obs_t e, o;
        e0 = err_count;
        err_rd = err_cyc.size();
        send_bits(8'h23, 1'b0, 1'b0, 5);
        repeat (15000) @(negedge pclk);
        m_ext = 1'b0;
        m_brk = 1'b0;
        compared++; if (err_count - e0 != 1) begin mismatched++; $display("[TB] FAIL timeout_err: got %0d errors want 1", err_count - e0); end
        compared++;
        if (err_cyc.size() > err_rd) begin
            lat = err_cyc[err_rd] - last_fall;
            if (lat < 13000 || lat > 13020) begin
                mismatched++; $display("[TB] FAIL timeout_time: got %0d cycles want 13000..13020", lat);
            end
        end else begin
            mismatched++; $display("[TB] FAIL timeout_time: got no frame_err want one");
        end
        compared++; if (obs_q.size() != obs_rd) begin mismatched++; $display("[TB] FAIL timeout_valid: got %0d valid pulses want 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
        send_good(8'h23, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_rd >= obs_q.size()) begin
                mismatched++; $display("[TB] FAIL timeout_missing: got nothing want sc=%h key=%b", e.sc, e.key);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.sc !== e.sc || o.key !== e.key) begin
                    mismatched++; $display("[TB] FAIL timeout_data: got sc=%h key=%b want sc=%h key=%b", o.sc, o.key, e.sc, e.key);
                end
            end
        end
    endtask

    task automatic test_glitch;
        int e0;
        obs_t e, o;
        e0 = err_count;
        ps2_data = 1'b1;
        repeat (5) begin
            ps2_clk = 1'b0;
            repeat (3) @(negedge pclk);
            ps2_clk = 1'b1;
            repeat (20) @(negedge pclk);
        end
        compared++; if (err_count - e0 != 0) begin mismatched++; $display("[TB] FAIL glitch_idle_err: got %0d errors want 0", err_count - e0); end
        compared++; if (obs_q.size() != obs_rd) begin mismatched++; $display("[TB] FAIL glitch_idle_valid: got %0d valid pulses want 0", obs_q.size() - obs_rd); obs_rd = obs_q.size(); end
        send_good(8'h1B, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_rd >= obs_q.size()) begin
                mismatched++; $display("[TB] FAIL glitch_missing: got nothing want sc=%h key=%b", e.sc, e.key);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.sc !== e.sc || o.key !== e.key) begin
                    mismatched++; $display("[TB] FAIL glitch_data: got sc=%h key=%b want sc=%h key=%b", o.sc, o.key, e.sc, e.key);
                end
            end
        end
        compared++; if (err_count - e0 != 0) begin mismatched++; $display("[TB] FAIL glitch_err: got %0d errors want 0", err_count - e0); end
    endtask

    task automatic test_reset_mid;
        int e0;
        obs_t e, o;
        send_bits(8'h1B, 1'b0, 1'b0, 4);
        rst = 1'b1;
        repeat (3) @(negedge pclk);
        compared++; if (key !== 4'b0) begin mismatched++; $display("[TB] FAIL midrst_key: got %b want 0000", key); end
        compared++; if (scancode !== 8'h00) begin mismatched++; $display("[TB] FAIL midrst_scancode: got %h want 00", scancode); end
        rst = 1'b0;
        m_key = 4'b0000;
        m_ext = 1'b0;
        m_brk = 1'b0;
        obs_rd = obs_q.size();
        e0 = err_count;
        repeat (5) @(negedge pclk);
        send_good(8'h1B, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (obs_rd >= obs_q.size()) begin
                mismatched++; $display("[TB] FAIL midrst_missing: got nothing want sc=%h key=%b", e.sc, e.key);
            end else begin
                o = obs_q[obs_rd]; obs_rd++;
                if (o.sc !== e.sc || o.key !== e.key) begin
                    mismatched++; $display("[TB] FAIL midrst_data: got sc=%h key=%b want sc=%h key=%b", o.sc, o.key, e.sc, e.key);
                end
            end
        end
        compared++; if (err_count - e0 != 0) begin mismatched++; $display("[TB] FAIL midrst_err: got %0d errors want 0", err_count - e0); end
        compared++; if (obs_q.size() != obs_rd) begin mismatched++; $display("[TB] FAIL midrst_extra: got %0d extra valid pulses want 0", obs_q.size() - obs_rd); end
    endtask

    initial begin
        @(negedge pclk);
        test_reset;
        test_make;
        test_ext;
        test_multi;
        test_parity_err;
        test_timeout;
        test_glitch;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
